// File: rtl/s_stream_feeder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : s_stream_feeder_pkg
// Description : Shared constants, nucleotide codes and state encodings for
//               the query-sequence feeder.
// Revision    : 1.0 - initial release
// ============================================================================
package s_stream_feeder_pkg;

    localparam int PE_ARRAY_SIZE = 32;
    localparam int PE_ARRAY_SIZE_LOG = $clog2(PE_ARRAY_SIZE);

    localparam logic [1:0] NT_A = 2'b00;
    localparam logic [1:0] NT_C = 2'b01;
    localparam logic [1:0] NT_G = 2'b10;
    localparam logic [1:0] NT_T = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FILL   = 2'd1,
        ST_STREAM = 2'd2,
        ST_DONE   = 2'd3
    } feeder_state_t;

    // Returns {legal, code}; legal is 0 for anything other than ACGT/acgt.
    function automatic logic [2:0] nt_encode(input logic [7:0] ch);
        logic [2:0] w_code;
        case (ch)
            8'h41, 8'h61: w_code = {1'b1, NT_A};
            8'h43, 8'h63: w_code = {1'b1, NT_C};
            8'h47, 8'h67: w_code = {1'b1, NT_G};
            8'h54, 8'h74: w_code = {1'b1, NT_T};
            default:      w_code = 3'b000;
        endcase
        return w_code;
    endfunction

endpackage
`default_nettype wire

// File: rtl/s_stream_feeder_if.sv
`default_nettype none
// ============================================================================
// Module      : s_stream_feeder_if
// Description : Host character stream and engine chunk-request bundle.
// Revision    : 1.0 - initial release
// ============================================================================
interface s_stream_feeder_if
    import s_stream_feeder_pkg::*;
#(
    parameter int PE_SIZE     = PE_ARRAY_SIZE,
    parameter int PE_SIZE_LOG = PE_ARRAY_SIZE_LOG
);
    logic                   i_seq_start;
    logic [7:0]             i_char;
    logic                   i_char_valid;
    logic                   i_char_last;
    logic                   o_char_ready;
    logic                   i_request_s;
    logic [2*PE_SIZE-1:0]   o_s;
    logic [PE_SIZE_LOG:0]   o_s_valid;
    logic                   o_s_ready;
    logic                   o_bad_char;
    logic                   o_underrun;

    modport slave (
        input  i_seq_start, i_char, i_char_valid, i_char_last, i_request_s,
        output o_char_ready, o_s, o_s_valid, o_s_ready, o_bad_char, o_underrun
    );

    modport master (
        output i_seq_start, i_char, i_char_valid, i_char_last, i_request_s,
        input  o_char_ready, o_s, o_s_valid, o_s_ready, o_bad_char, o_underrun
    );
endinterface
`default_nettype wire

// File: rtl/s_stream_feeder_chunk_fifo.sv
`default_nettype none
// ============================================================================
// Module      : s_chunk_fifo
// Description : Two-entry chunk buffer (data + count) with simultaneous
//               push/pop and synchronous flush.
// Revision    : 1.0 - initial release
// ============================================================================
module s_chunk_fifo #(
    parameter int DATA_W = 64,
    parameter int CNT_W  = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_flush,
    input  logic              i_push,
    input  logic [DATA_W-1:0] i_push_data,
    input  logic [CNT_W-1:0]  i_push_cnt,
    input  logic              i_pop,
    output logic [DATA_W-1:0] o_head_data,
    output logic [CNT_W-1:0]  o_head_cnt,
    output logic              o_full,
    output logic              o_empty
);
    logic [DATA_W-1:0] r_data [2];
    logic [CNT_W-1:0]  r_cnt  [2];
    logic              r_wr_ptr;
    logic              r_rd_ptr;
    logic [1:0]        r_level;
    logic              w_do_push;
    logic              w_do_pop;

    assign o_full      = (r_level == 2'd2);
    assign o_empty     = (r_level == 2'd0);
    assign o_head_data = r_data[r_rd_ptr];
    assign o_head_cnt  = r_cnt[r_rd_ptr];
    assign w_do_push   = i_push & ~o_full;
    assign w_do_pop    = i_pop & ~o_empty;

    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_level  <= 2'd0;
        end else begin
            if (w_do_push) begin
                r_data[r_wr_ptr] <= i_push_data;
                r_cnt[r_wr_ptr]  <= i_push_cnt;
                r_wr_ptr         <= ~r_wr_ptr;
            end
            if (w_do_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_level <= r_level + {1'b0, w_do_push} - {1'b0, w_do_pop};
        end
    end
endmodule
`default_nettype wire

// File: rtl/s_stream_feeder.sv
`default_nettype none
// ============================================================================
// Module      : s_stream_feeder
// Description : Packs an ASCII nucleotide stream into PE-array-wide 2-bit
//               chunks and answers engine requests from a 2-entry buffer.
// Revision    : 1.0 - initial release
// ============================================================================
module s_stream_feeder
    import s_stream_feeder_pkg::*;
#(
    parameter int PE_SIZE     = PE_ARRAY_SIZE,
    parameter int PE_SIZE_LOG = PE_ARRAY_SIZE_LOG
) (
    input  logic             clk,
    input  logic             rst,
    s_stream_feeder_if.slave bus
);
    localparam logic [PE_SIZE_LOG:0] c_full_cnt = (PE_SIZE_LOG+1)'(PE_SIZE);

    feeder_state_t          r_state, w_state_nxt;
    logic [2*PE_SIZE-1:0]   r_pack_data, w_new_data, r_resp_data, r_s, w_head_data, w_push_data;
    logic [PE_SIZE_LOG:0]   r_pack_cnt, w_new_cnt, r_resp_cnt, r_s_valid, w_head_cnt, w_push_cnt;
    logic                   r_last_seen, r_marker_pending, r_bad_char, r_underrun;
    logic                   r_resp_pending, r_resp_under;
    logic                   w_full, w_empty, w_active, w_char_ready, w_accept, w_good;
    logic                   w_close, w_marker_push, w_push, w_pop, w_term_pop;
    logic [2:0]             w_nt;

    assign w_nt          = nt_encode(bus.i_char);
    assign w_active      = (r_state == ST_FILL) || (r_state == ST_STREAM);
    assign w_char_ready  = w_active & ~w_full & ~r_last_seen;
    assign w_accept      = bus.i_char_valid & w_char_ready;
    assign w_good        = w_accept & w_nt[2];
    assign w_new_cnt     = r_pack_cnt + {{PE_SIZE_LOG{1'b0}}, w_good};
    assign w_close       = w_accept & ((w_new_cnt == c_full_cnt) | bus.i_char_last);
    assign w_marker_push = r_marker_pending & ~w_full;
    assign w_push        = ~bus.i_seq_start & (w_close | w_marker_push);
    assign w_push_data   = w_close ? w_new_data : '0;
    assign w_push_cnt    = w_close ? w_new_cnt  : '0;
    assign w_pop         = bus.i_request_s & ~bus.i_seq_start & w_active & ~w_empty;
    // Any chunk shorter than a full array ends the sequence.
    assign w_term_pop    = w_pop & (w_head_cnt != c_full_cnt);

    always_comb begin
        w_new_data = r_pack_data;
        if (w_good) begin
            w_new_data[{r_pack_cnt[PE_SIZE_LOG-1:0], 1'b0} +: 2] = w_nt[1:0];
        end
    end

    s_chunk_fifo #(
        .DATA_W (2*PE_SIZE),
        .CNT_W  (PE_SIZE_LOG+1)
    ) u_chunk_fifo (
        .clk         (clk),
        .rst         (rst),
        .i_flush     (bus.i_seq_start),
        .i_push      (w_push),
        .i_push_data (w_push_data),
        .i_push_cnt  (w_push_cnt),
        .i_pop       (w_pop),
        .o_head_data (w_head_data),
        .o_head_cnt  (w_head_cnt),
        .o_full      (w_full),
        .o_empty     (w_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        if (bus.i_seq_start) begin
            w_state_nxt = ST_FILL;
        end else begin
            case (r_state)
                ST_IDLE:   w_state_nxt = ST_IDLE;
                ST_FILL:   if (w_term_pop) w_state_nxt = ST_DONE;
                           else if (!w_empty) w_state_nxt = ST_STREAM;
                ST_STREAM: if (w_term_pop) w_state_nxt = ST_DONE;
                ST_DONE:   w_state_nxt = ST_IDLE;
                default:   w_state_nxt = ST_IDLE;
            endcase
        end
    end

    // Stage 1 pops at the request edge; stage 2 presents the result one edge later.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pack_data      <= '0;
            r_pack_cnt       <= '0;
            r_last_seen      <= 1'b0;
            r_marker_pending <= 1'b0;
            r_bad_char       <= 1'b0;
            r_underrun       <= 1'b0;
            r_resp_pending   <= 1'b0;
            r_resp_under     <= 1'b0;
            r_resp_data      <= '0;
            r_resp_cnt       <= '0;
            r_s              <= '0;
            r_s_valid        <= '0;
        end else begin
            if (r_resp_pending) begin
                r_s       <= r_resp_data;
                r_s_valid <= r_resp_cnt;
                if (r_resp_under) r_underrun <= 1'b1;
            end
            if (bus.i_seq_start) begin
                r_pack_data      <= '0;
                r_pack_cnt       <= '0;
                r_last_seen      <= 1'b0;
                r_marker_pending <= 1'b0;
                r_bad_char       <= 1'b0;
                r_underrun       <= 1'b0;
                r_resp_pending   <= bus.i_request_s;
                r_resp_under     <= 1'b0;
                r_resp_data      <= '0;
                r_resp_cnt       <= '0;
            end else begin
                if (w_close) begin
                    r_pack_data <= '0;
                    r_pack_cnt  <= '0;
                end else if (w_good) begin
                    r_pack_data <= w_new_data;
                    r_pack_cnt  <= w_new_cnt;
                end
                if (w_accept && bus.i_char_last) begin
                    r_last_seen      <= 1'b1;
                    r_marker_pending <= (w_new_cnt == c_full_cnt);
                end else if (w_marker_push) begin
                    r_marker_pending <= 1'b0;
                end
                if (w_accept && !w_nt[2]) r_bad_char <= 1'b1;
                r_resp_pending <= bus.i_request_s;
                r_resp_under   <= bus.i_request_s & w_active & w_empty;
                r_resp_data    <= w_pop ? w_head_data : '0;
                r_resp_cnt     <= w_pop ? w_head_cnt  : '0;
            end
        end
    end

    assign bus.o_char_ready = w_char_ready;
    assign bus.o_s          = r_s;
    assign bus.o_s_valid    = r_s_valid;
    assign bus.o_s_ready    = (r_state == ST_STREAM) || (r_state == ST_DONE);
    assign bus.o_bad_char   = r_bad_char;
    assign bus.o_underrun   = r_underrun;
endmodule
`default_nettype wire

// File: tb/tb_s_stream_feeder.sv
`default_nettype none
// ============================================================================
// Module      : tb_s_stream_feeder
// Description : Self-checking bench: directed scenarios plus random streams
//               compared against a queue-based chunking model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_s_stream_feeder;
    logic clk = 1'b0;
    logic rst;

    s_stream_feeder_if bus ();

    s_stream_feeder dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0]  seq_q[$];
    logic [63:0] exp_data_q[$];
    int          exp_cnt_q[$];
    int          exp_idx_q[$];
    bit          bad_exp;
    int          n_acc;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic int nt_code(input logic [7:0] ch);
        case (ch)
            "A", "a": return 0;
            "C", "c": return 1;
            "G", "g": return 2;
            "T", "t": return 3;
            default:  return -1;
        endcase
    endfunction

    // Chunks: cut every 32 legal characters; at the last character the
    // current remainder (possibly empty) is emitted as the terminator.
    function automatic void build_model();
        logic [63:0] d;
        int cnt;
        int c;
        exp_data_q.delete(); exp_cnt_q.delete(); exp_idx_q.delete();
        d = '0; cnt = 0; bad_exp = 1'b0;
        for (int i = 0; i < seq_q.size(); i++) begin
            c = nt_code(seq_q[i]);
            if (c < 0) begin
                bad_exp = 1'b1;
            end else begin
                d[2*cnt +: 2] = c[1:0];
                cnt++;
                if (cnt == 32) begin
                    exp_data_q.push_back(d); exp_cnt_q.push_back(32); exp_idx_q.push_back(i);
                    d = '0; cnt = 0;
                end
            end
            if (i == seq_q.size() - 1) begin
                exp_data_q.push_back(d); exp_cnt_q.push_back(cnt); exp_idx_q.push_back(i);
            end
        end
    endfunction

    task automatic load_str(input string s);
        seq_q.delete();
        for (int i = 0; i < s.len(); i++) seq_q.push_back(s[i]);
    endtask

    task automatic gen_seq(input int len, input int bad_pct);
        logic [7:0] pool [8] = '{"A", "C", "G", "T", "a", "c", "g", "t"};
        seq_q.delete();
        for (int i = 0; i < len; i++) begin
            if ($urandom_range(99) < bad_pct) seq_q.push_back(8'($urandom_range(57, 48)));
            else                              seq_q.push_back(pool[$urandom_range(7)]);
        end
    endtask

    task automatic seq_start();
        bus.i_seq_start = 1'b1;
        cyc();
        bus.i_seq_start = 1'b0;
        n_acc = 0;
    endtask

    task automatic send_char(input logic [7:0] ch, input bit last);
        bit ok;
        int budget;
        budget = 0;
        bus.i_char = ch; bus.i_char_valid = 1'b1; bus.i_char_last = last;
        forever begin
            @(negedge clk);
            ok = bus.o_char_ready;
            @(posedge clk);
            budget++;
            if (ok || budget > 3000) break;
        end
        check_eq("char_accept", ok, 1);
        #1;
        bus.i_char_valid = 1'b0; bus.i_char_last = 1'b0;
    endtask

    task automatic run_host(input bit with_last, input int gap_max);
        for (int i = 0; i < seq_q.size(); i++) begin
            repeat ($urandom_range(gap_max)) cyc();
            send_char(seq_q[i], with_last && (i == seq_q.size() - 1));
            n_acc++;
        end
    endtask

    task automatic do_request(output logic [63:0] d, output int v);
        bus.i_request_s = 1'b1;
        cyc();
        bus.i_request_s = 1'b0;
        cyc();
        d = bus.o_s;
        v = int'(bus.o_s_valid);
    endtask

    task automatic wait_acc(input int n);
        int guard;
        guard = 0;
        while (n_acc < n && guard < 5000) begin cyc(); guard++; end
        check_eq("wait_acc", n_acc >= n, 1);
    endtask

    task automatic run_req();
        logic [63:0] d;
        int v;
        for (int j = 0; j < exp_cnt_q.size(); j++) begin
            wait_acc(exp_idx_q[j] + 1);
            repeat (3 + $urandom_range(2)) cyc();
            do_request(d, v);
            check_eq($sformatf("chunk%0d_valid", j), v, exp_cnt_q[j]);
            check_eq($sformatf("chunk%0d_data", j), d, exp_data_q[j]);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] d;
        int v;
        bus.i_seq_start = 1'b0; bus.i_char = '0; bus.i_char_valid = 1'b0;
        bus.i_char_last = 1'b0; bus.i_request_s = 1'b0;
        n_acc = 0;
        rst = 1'b1;
        cyc(); cyc();
        check_eq("rst_s", bus.o_s, 0);
        check_eq("rst_s_valid", bus.o_s_valid, 0);
        check_eq("rst_char_ready", bus.o_char_ready, 0);
        check_eq("rst_s_ready", bus.o_s_ready, 0);
        check_eq("rst_bad", bus.o_bad_char, 0);
        check_eq("rst_underrun", bus.o_underrun, 0);
        rst = 1'b0;
        cyc();

        // ACGT
        seq_start();
        load_str("ACGT");
        run_host(1, 0);
        repeat (3) cyc();
        check_eq("acgt_s_ready", bus.o_s_ready, 1);
        do_request(d, v);
        check_eq("acgt_valid", v, 4);
        check_eq("acgt_data", d, 64'hE4);
        check_eq("acgt_done_idle", bus.o_s_ready, 0);

        // 32 x A with end marker
        seq_start();
        load_str("AAAAAAAAAAAAAAAAAAAAAAAAAAAAAAAA");
        run_host(1, 0);
        repeat (3) cyc();
        do_request(d, v);
        check_eq("a32_valid", v, 32);
        check_eq("a32_data", d, 0);
        do_request(d, v);
        check_eq("marker_valid", v, 0);
        check_eq("marker_data", d, 0);
        check_eq("a32_underrun", bus.o_underrun, 0);

        // 70 characters with backpressure
        seq_start();
        gen_seq(70, 0);
        build_model();
        fork
            run_host(1, 0);
            begin
                wait_acc(64);
                repeat (4) cyc();
                check_eq("stall_ready", bus.o_char_ready, 0);
                check_eq("stall_acc", n_acc, 64);
                check_eq("stall_s_ready", bus.o_s_ready, 1);
                run_req();
            end
        join
        check_eq("c70_n_chunks", exp_cnt_q.size(), 3);

        // illegal character
        seq_start();
        load_str("AXG");
        run_host(1, 0);
        repeat (3) cyc();
        check_eq("axg_bad", bus.o_bad_char, 1);
        do_request(d, v);
        check_eq("axg_valid", v, 2);
        check_eq("axg_data", d, 64'h8);

        // reset mid-stream
        seq_start();
        gen_seq(10, 0);
        run_host(0, 0);
        rst = 1'b1;
        cyc();
        check_eq("mid_rst_s", bus.o_s, 0);
        check_eq("mid_rst_s_valid", bus.o_s_valid, 0);
        check_eq("mid_rst_char_ready", bus.o_char_ready, 0);
        check_eq("mid_rst_s_ready", bus.o_s_ready, 0);
        rst = 1'b0;
        seq_start();
        load_str("T");
        run_host(1, 0);
        repeat (3) cyc();
        do_request(d, v);
        check_eq("t_valid", v, 1);
        check_eq("t_data", d, 64'h3);

        // underrun, flush clearing, flush beating a request
        seq_start();
        do_request(d, v);
        check_eq("under_valid", v, 0);
        check_eq("under_data", d, 0);
        check_eq("under_flag", bus.o_underrun, 1);
        seq_start();
        check_eq("under_cleared", bus.o_underrun, 0);
        load_str("ACGT");
        run_host(1, 0);
        repeat (3) cyc();
        bus.i_seq_start = 1'b1; bus.i_request_s = 1'b1;
        cyc();
        bus.i_seq_start = 1'b0; bus.i_request_s = 1'b0;
        cyc();
        check_eq("flush_req_valid", bus.o_s_valid, 0);
        check_eq("flush_req_under", bus.o_underrun, 0);
        check_eq("flush_ready", bus.o_char_ready, 1);

        // random streams
        for (int it = 0; it < 8; it++) begin
            int len;
            if ($urandom_range(2) == 0) len = 32 * $urandom_range(2, 1);
            else                        len = $urandom_range(90, 1);
            seq_start();
            gen_seq(len, ($urandom_range(1) == 1) ? 10 : 0);
            build_model();
            fork
                run_host(1, 3);
                run_req();
            join
            check_eq($sformatf("rnd%0d_bad", it), bus.o_bad_char, bad_exp);
            check_eq($sformatf("rnd%0d_underrun", it), bus.o_underrun, 0);
            check_eq($sformatf("rnd%0d_idle", it), bus.o_s_ready, 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/s_stream_feeder.md
Name: s_stream_feeder

Overview:
Upstream stage of the top-level Smith-Waterman engine. Takes query sequence S from a host byte stream (ASCII A/C/G/T), converts each character to a 2-bit code and packs the codes into PE-array-wide chunks. Answers the engine's o_request_s pulses with one chunk per request on the engine's i_s / i_s_valid inputs. Uses a 2-entry chunk buffer so every request is answered with fixed 1-cycle latency.

Parameters:
PE_SIZE, 32, nucleotides per chunk (equals PE_Array_size)
PE_SIZE_LOG, 5, log2(PE_SIZE)

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
i_seq_start  in  1  pulse; begin new S sequence, flushes buffers
i_char  in  8  ASCII nucleotide from host
i_char_valid  in  1  host data valid
i_char_last  in  1  marks final character of S (qualified by valid)
o_char_ready  out  1  feeder accepts i_char this cycle
i_request_s  in  1  from engine o_request_s
o_s  out  PE_SIZE*2  chunk; nucleotide k in bits [2k+1:2k]
o_s_valid  out  PE_SIZE_LOG+1  number of valid nucleotides in o_s
o_s_ready  out  1  first chunk buffered; host may pulse i_start_cal
o_bad_char  out  1  sticky: non-ACGT character seen
o_underrun  out  1  sticky: request arrived with buffer empty

Behaviour:
- Reset: all outputs 0; state IDLE; buffer empty; packer count 0.
- Coding: 'A'/'a'=00, 'C'/'c'=01, 'G'/'g'=10, 'T'/'t'=11. Any other byte: dropped (not packed), o_bad_char set. If that byte carries last, the chunk still closes.
- Handshake: transfer when i_char_valid & o_char_ready. o_char_ready = (state==FILL or STREAM) & buffer not full & !last_seen.
- Packer: shift register plus count 0..PE_SIZE. Chunk closes when count reaches PE_SIZE or on an accepted last. A closed chunk is pushed into the buffer with its count.
- If last closes a full chunk (count==PE_SIZE), an extra zero-count chunk is pushed afterwards as the end marker. Any chunk with count<PE_SIZE terminates S.
- Buffer: 2 entries. Push and pop in the same cycle are both allowed. Push into a full buffer never happens because ready gates input. The end-marker push waits for a free slot.
- States:
  - IDLE -> FILL on i_seq_start.
  - FILL -> STREAM when buffer holds at least 1 chunk; o_s_ready=1 from this transition on.
  - STREAM -> DONE when the terminating chunk is popped.
  - DONE -> IDLE next cycle, o_s_ready cleared.
  - i_seq_start in any state: flushes buffer and packer, clears sticky flags, goes to FILL.
- Response: i_request_s sampled high at edge N. At edge N+1, o_s/o_s_valid take the buffer head, which is popped. Values hold until the next request.
- Request with empty buffer: o_s_valid=0, o_s=0, o_underrun set. Request in IDLE/DONE: same response, but o_underrun is not set.
- Simultaneous events:
  - Request and packer close in the same cycle with the buffer empty: the request sees empty (underrun); the chunk enters the buffer.
  - i_seq_start with a request: the flush wins, response is 0.
- Reset asserted mid-operation: returns to reset values at the next edge; the partial chunk is discarded.

Decomposition:
- Shared package: nucleotide code constants (NT_A..NT_T), PE_SIZE/PE_SIZE_LOG tied to the global PE_Array_size defines, feeder state encodings.
- One sub-module is natural: s_chunk_fifo (2-entry, data + count, push/pop/full/empty).

Test Plan:
- Send "ACGT" with last, then request -> o_s_valid=4, o_s[7:0]=8'b11_10_01_00; upper bits 0; state reaches DONE.
- Send 32 'A' with last on the 32nd, then two requests -> first o_s_valid=32 with o_s all 0; second o_s_valid=0 (end marker).
- Send 70 chars; host holds valid continuously; request only after o_s_ready -> valid counts 32, 32, 6. o_char_ready drops while buffer holds 2 chunks.
- Send "AXG" with last -> o_bad_char=1; chunk o_s_valid=2, o_s[3:0]=4'b10_00.
- Pulse request in FILL before any char -> o_underrun=1 and o_s_valid=0. Next i_seq_start clears o_underrun.
- Assert rst mid-stream after 10 chars -> all outputs 0 next edge. Then i_seq_start + "T" last + request -> o_s_valid=1, o_s[1:0]=11.
